// File: rtl/layer_addr_sched_if.sv
// Handshake/bus bundle between the layer FSM / MAC side and the per-layer loop sequencer.
// master drives layer state, cfg and mac_ready; slave is the sequencer that issues reads and write-backs.
interface layer_addr_sched_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8
);
    logic [2:0]        state;
    logic [CNT_W-1:0]  cfg_oc;
    logic [CNT_W-1:0]  cfg_pix;
    logic [CNT_W-1:0]  cfg_k;
    logic [ADDR_W-1:0] cfg_act_base;
    logic [ADDR_W-1:0] cfg_wgt_base;
    logic [ADDR_W-1:0] cfg_out_base;
    logic              mac_ready;
    logic              rd_valid;
    logic [ADDR_W-1:0] act_addr;
    logic [ADDR_W-1:0] wgt_addr;
    logic              acc_clear;
    logic              acc_last;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              change_state;
    logic              busy;

    modport master (
        output state, cfg_oc, cfg_pix, cfg_k, cfg_act_base, cfg_wgt_base, cfg_out_base, mac_ready,
        input  rd_valid, act_addr, wgt_addr, acc_clear, acc_last, wr_en, wr_addr, change_state, busy
    );

    modport slave (
        input  state, cfg_oc, cfg_pix, cfg_k, cfg_act_base, cfg_wgt_base, cfg_out_base, mac_ready,
        output rd_valid, act_addr, wgt_addr, acc_clear, acc_last, wr_en, wr_addr, change_state, busy
    );
endinterface

// File: rtl/layer_addr_sched.sv
// Purpose: walks the oc/pix/k loop nest of one CNN layer, issuing act/wgt reads and output write-backs.
// Latency: first read the cycle after a layer start; write-back PIPE_LAT cycles after each last-step issue.
// Backpressure: mac_ready low holds the current issue stable; the write-back pipe keeps advancing regardless.
module layer_addr_sched #(
    parameter int ADDR_W   = 16,
    parameter int CNT_W    = 8,
    parameter int PIPE_LAT = 3
) (
    input logic               clk,
    input logic               rst_n,
    layer_addr_sched_if.slave sif
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_PULSE} fsm_t;

    fsm_t              fsm;
    logic [2:0]        prev_state;
    logic [2:0]        layer_q;
    logic [CNT_W-1:0]  oc_q, pix_q, k_q;
    logic [CNT_W-1:0]  k_cnt, pix_cnt, oc_cnt;
    logic [ADDR_W-1:0] act_base_q;
    logic [ADDR_W-1:0] act_ptr, wgt_ptr, wgt_row, out_ptr;
    logic              rd_valid_q, acc_clear_q, acc_last_q, change_q, busy_q;
    logic [PIPE_LAT-1:0] pipe_vld;
    logic [ADDR_W-1:0]   pipe_addr [PIPE_LAT];

    logic             is_layer, start, zero_cfg, fire;
    logic             last_k, last_pix, last_oc, drain_done;
    logic [CNT_W-1:0] k_nxt;
    logic [PIPE_LAT-1:0] pipe_early;

    always_comb begin
        is_layer   = (sif.state >= 3'd1) && (sif.state <= 3'd5);
        start      = is_layer && (sif.state != prev_state);
        zero_cfg   = (sif.cfg_oc == '0) || (sif.cfg_pix == '0) || (sif.cfg_k == '0);
        fire       = rd_valid_q && sif.mac_ready;
        last_k     = (k_cnt   == k_q   - CNT_W'(1));
        last_pix   = (pix_cnt == pix_q - CNT_W'(1));
        last_oc    = (oc_cnt  == oc_q  - CNT_W'(1));
        k_nxt      = last_k ? '0 : k_cnt + CNT_W'(1);
        // Drain ends once only the oldest stage (the one on wr_en now) still holds a write.
        pipe_early = pipe_vld;
        pipe_early[PIPE_LAT-1] = 1'b0;
        drain_done = (pipe_early == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= S_IDLE;
            prev_state  <= '0;
            layer_q     <= '0;
            oc_q        <= '0;
            pix_q       <= '0;
            k_q         <= '0;
            k_cnt       <= '0;
            pix_cnt     <= '0;
            oc_cnt      <= '0;
            act_base_q  <= '0;
            act_ptr     <= '0;
            wgt_ptr     <= '0;
            wgt_row     <= '0;
            out_ptr     <= '0;
            rd_valid_q  <= 1'b0;
            acc_clear_q <= 1'b0;
            acc_last_q  <= 1'b0;
            change_q    <= 1'b0;
            busy_q      <= 1'b0;
            pipe_vld    <= '0;
            for (int i = 0; i < PIPE_LAT; i++) pipe_addr[i] <= '0;
        end else begin
            prev_state   <= sif.state;
            change_q     <= 1'b0;
            pipe_vld[0]  <= fire && acc_last_q;
            pipe_addr[0] <= out_ptr;
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end

            if (start) begin
                // A new compute layer always wins, including over a layer still in flight.
                layer_q    <= sif.state;
                oc_q       <= sif.cfg_oc;
                pix_q      <= sif.cfg_pix;
                k_q        <= sif.cfg_k;
                act_base_q <= sif.cfg_act_base;
                act_ptr    <= sif.cfg_act_base;
                wgt_ptr    <= sif.cfg_wgt_base;
                wgt_row    <= sif.cfg_wgt_base;
                out_ptr    <= sif.cfg_out_base;
                k_cnt      <= '0;
                pix_cnt    <= '0;
                oc_cnt     <= '0;
                pipe_vld   <= '0;
                if (zero_cfg) begin
                    fsm         <= S_PULSE;
                    change_q    <= 1'b1;
                    busy_q      <= 1'b0;
                    rd_valid_q  <= 1'b0;
                    acc_clear_q <= 1'b0;
                    acc_last_q  <= 1'b0;
                end else begin
                    fsm         <= S_RUN;
                    busy_q      <= 1'b1;
                    rd_valid_q  <= 1'b1;
                    acc_clear_q <= 1'b1;
                    acc_last_q  <= (sif.cfg_k == CNT_W'(1));
                end
            end else if (busy_q && (sif.state != layer_q)) begin
                fsm         <= S_IDLE;
                busy_q      <= 1'b0;
                rd_valid_q  <= 1'b0;
                acc_clear_q <= 1'b0;
                acc_last_q  <= 1'b0;
                pipe_vld    <= '0;
            end else begin
                case (fsm)
                    S_RUN: begin
                        if (fire) begin
                            if (acc_last_q) out_ptr <= out_ptr + ADDR_W'(1);
                            k_cnt       <= k_nxt;
                            acc_clear_q <= (k_nxt == '0);
                            acc_last_q  <= (k_nxt == k_q - CNT_W'(1));
                            if (!last_k) begin
                                act_ptr <= act_ptr + ADDR_W'(1);
                                wgt_ptr <= wgt_ptr + ADDR_W'(1);
                            end else if (!last_pix) begin
                                // act rows are contiguous per pixel; weights replay the same oc row.
                                pix_cnt <= pix_cnt + CNT_W'(1);
                                act_ptr <= act_ptr + ADDR_W'(1);
                                wgt_ptr <= wgt_row;
                            end else if (!last_oc) begin
                                pix_cnt <= '0;
                                oc_cnt  <= oc_cnt + CNT_W'(1);
                                act_ptr <= act_base_q;
                                wgt_row <= wgt_row + ADDR_W'(k_q);
                                wgt_ptr <= wgt_row + ADDR_W'(k_q);
                            end else begin
                                fsm         <= S_DRAIN;
                                rd_valid_q  <= 1'b0;
                                acc_clear_q <= 1'b0;
                                acc_last_q  <= 1'b0;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (drain_done) begin
                            fsm      <= S_PULSE;
                            busy_q   <= 1'b0;
                            change_q <= 1'b1;
                        end
                    end
                    S_PULSE: fsm <= S_IDLE;
                    default: ;
                endcase
            end
        end
    end

    assign sif.rd_valid     = rd_valid_q;
    assign sif.act_addr     = act_ptr;
    assign sif.wgt_addr     = wgt_ptr;
    assign sif.acc_clear    = acc_clear_q;
    assign sif.acc_last     = acc_last_q;
    assign sif.wr_en        = pipe_vld[PIPE_LAT-1];
    assign sif.wr_addr      = pipe_addr[PIPE_LAT-1];
    assign sif.change_state = change_q;
    assign sif.busy         = busy_q;
endmodule

// File: tb/tb_layer_addr_sched.sv
// Directed bench for layer_addr_sched: basic layer, stall, zero config, back-to-back, abort, async reset.
module tb_layer_addr_sched;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    layer_addr_sched_if #(.ADDR_W(16), .CNT_W(8)) sif ();

    layer_addr_sched #(.ADDR_W(16), .CNT_W(8), .PIPE_LAT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    // per-cycle record, index = cycles after the start cycle T
    logic        rv [64];
    logic        ac [64];
    logic        al [64];
    logic        we [64];
    logic        cs [64];
    logic        by [64];
    logic [15:0] aa [64];
    logic [15:0] wa [64];
    logic [15:0] wad[64];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_cfg(input logic [2:0] st, input logic [7:0] oc, input logic [7:0] pix,
                           input logic [7:0] k, input logic [15:0] ab, input logic [15:0] wb,
                           input logic [15:0] ob);
        sif.state        = st;
        sif.cfg_oc       = oc;
        sif.cfg_pix      = pix;
        sif.cfg_k        = k;
        sif.cfg_act_base = ab;
        sif.cfg_wgt_base = wb;
        sif.cfg_out_base = ob;
    endtask

    // Call at the negedge of start cycle T (state already set); records cycles T+1..T+n.
    task automatic run_rec(input int n, input int stall_at, input int stall_len,
                           input int abort_at, input int chg_at);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            rv[c] = sif.rd_valid;  ac[c] = sif.acc_clear; al[c] = sif.acc_last;
            we[c] = sif.wr_en;     cs[c] = sif.change_state; by[c] = sif.busy;
            aa[c] = sif.act_addr;  wa[c] = sif.wgt_addr;  wad[c] = sif.wr_addr;
            sif.mac_ready = !(c >= stall_at && c < stall_at + stall_len);
            if (c == abort_at) sif.state = 3'd0;
            if (c == chg_at) set_cfg(3'd2, 8'd1, 8'd2, 8'd1, 16'h40, 16'h50, 16'h60);
            if (chg_at > 0 && c == chg_at + 1) set_cfg(3'd2, 8'd0, 8'hff, 8'd0, 16'hdead, 16'hbeef, 16'hface);
        end
    endtask

    task automatic idle_gap();
        sif.state = 3'd0;
        sif.mac_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Basic layer oc=2 pix=2 k=3, bases 100/200/300; sh = stall cycles inserted after the first issue.
    task automatic check_layer(input string p, input int sh, input int n);
        int act_tab[12];
        int wgt_tab[12];
        act_tab = '{'h100, 'h101, 'h102, 'h103, 'h104, 'h105, 'h100, 'h101, 'h102, 'h103, 'h104, 'h105};
        wgt_tab = '{'h200, 'h201, 'h202, 'h200, 'h201, 'h202, 'h203, 'h204, 'h205, 'h203, 'h204, 'h205};
        for (int i = 0; i < 12; i++) begin
            int ic;
            ic = (i == 0) ? 1 : i + 1 + sh;
            chk($sformatf("%s_act%0d", p, i), 32'(aa[ic]), act_tab[i]);
            chk($sformatf("%s_wgt%0d", p, i), 32'(wa[ic]), wgt_tab[i]);
            chk($sformatf("%s_clr%0d", p, i), 32'(ac[ic]), 32'(i % 3 == 0));
            chk($sformatf("%s_lst%0d", p, i), 32'(al[ic]), 32'(i % 3 == 2));
        end
        for (int c = 1; c <= n; c++) begin
            logic        e;
            logic [31:0] ea;
            e = 1'b0;
            ea = 32'h0;
            for (int j = 0; j < 4; j++)
                if (c == 6 + 3 * j + sh) begin e = 1'b1; ea = 32'h300 + 32'(j); end
            chk($sformatf("%s_rv@%0d", p, c), 32'(rv[c]), 32'(c <= 12 + sh));
            chk($sformatf("%s_we@%0d", p, c), 32'(we[c]), 32'(e));
            if (e) chk($sformatf("%s_wad@%0d", p, c), 32'(wad[c]), ea);
            chk($sformatf("%s_cs@%0d", p, c), 32'(cs[c]), 32'(c == 16 + sh));
            chk($sformatf("%s_busy@%0d", p, c), 32'(by[c]), 32'(c <= 15 + sh));
        end
    endtask

    initial begin
        int npulse;
        rst_n = 1'b0;
        sif.mac_ready = 1'b1;
        set_cfg(3'd0, 8'd0, 8'd0, 8'd0, 16'h0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        chk("rst_rv", 32'(sif.rd_valid), 0);
        chk("rst_we", 32'(sif.wr_en), 0);
        chk("rst_cs", 32'(sif.change_state), 0);
        chk("rst_busy", 32'(sif.busy), 0);
        chk("rst_act", 32'(sif.act_addr), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // basic layer
        set_cfg(3'd1, 8'd2, 8'd2, 8'd3, 16'h100, 16'h200, 16'h300);
        run_rec(20, 0, 0, 0, 0);
        check_layer("basic", 0, 20);
        idle_gap();

        // stall: mac_ready low in T+2, T+3
        set_cfg(3'd1, 8'd2, 8'd2, 8'd3, 16'h100, 16'h200, 16'h300);
        run_rec(22, 2, 2, 0, 0);
        chk("stall_hold2", 32'(aa[2]), 32'h101);
        chk("stall_hold3", 32'(aa[3]), 32'h101);
        chk("stall_rv3", 32'(rv[3]), 1);
        check_layer("stall", 2, 22);
        idle_gap();

        // zero config
        set_cfg(3'd1, 8'd2, 8'd2, 8'd0, 16'h100, 16'h200, 16'h300);
        run_rec(6, 0, 0, 0, 0);
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("zero_rv@%0d", c), 32'(rv[c]), 0);
            chk($sformatf("zero_we@%0d", c), 32'(we[c]), 0);
            chk($sformatf("zero_cs@%0d", c), 32'(cs[c]), 32'(c == 1));
            chk($sformatf("zero_busy@%0d", c), 32'(by[c]), 0);
        end
        idle_gap();

        // back-to-back: layer 1 (1x1x2), FSM moves to layer 2 (1x2x1) after the pulse
        set_cfg(3'd1, 8'd1, 8'd1, 8'd2, 16'h10, 16'h20, 16'h30);
        run_rec(16, 0, 0, 0, 7);
        chk("b2b_rv1", 32'(rv[1]), 1);
        chk("b2b_rv2", 32'(rv[2]), 1);
        chk("b2b_rv7", 32'(rv[7]), 0);
        chk("b2b_we5", 32'(we[5]), 1);
        chk("b2b_wad5", 32'(wad[5]), 32'h30);
        chk("b2b_cs6", 32'(cs[6]), 1);
        chk("b2b_rv8", 32'(rv[8]), 1);
        chk("b2b_act8", 32'(aa[8]), 32'h40);
        chk("b2b_wgt8", 32'(wa[8]), 32'h50);
        chk("b2b_act9", 32'(aa[9]), 32'h41);
        chk("b2b_wgt9", 32'(wa[9]), 32'h50);
        chk("b2b_lst8", 32'(al[8]), 1);
        chk("b2b_lst9", 32'(al[9]), 1);
        chk("b2b_rv10", 32'(rv[10]), 0);
        chk("b2b_we11", 32'(we[11]), 1);
        chk("b2b_wad11", 32'(wad[11]), 32'h60);
        chk("b2b_we12", 32'(we[12]), 1);
        chk("b2b_wad12", 32'(wad[12]), 32'h61);
        chk("b2b_cs13", 32'(cs[13]), 1);
        npulse = 0;
        for (int c = 1; c <= 16; c++) npulse += int'(cs[c]);
        chk("b2b_npulse", 32'(npulse), 2);
        idle_gap();

        // abort: state forced to IDLE in T+5
        set_cfg(3'd1, 8'd2, 8'd2, 8'd3, 16'h100, 16'h200, 16'h300);
        run_rec(20, 0, 0, 5, 0);
        chk("abort_rv5", 32'(rv[5]), 1);
        chk("abort_busy6", 32'(by[6]), 0);
        for (int c = 6; c <= 20; c++) chk($sformatf("abort_rv@%0d", c), 32'(rv[c]), 0);
        for (int c = 1; c <= 20; c++) begin
            chk($sformatf("abort_we@%0d", c), 32'(we[c]), 0);
            chk($sformatf("abort_cs@%0d", c), 32'(cs[c]), 0);
        end
        idle_gap();

        // async reset mid-RUN, then a clean basic layer
        set_cfg(3'd1, 8'd2, 8'd2, 8'd3, 16'h100, 16'h200, 16'h300);
        repeat (4) @(negedge clk);
        chk("arst_pre_rv", 32'(sif.rd_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_rv", 32'(sif.rd_valid), 0);
        chk("arst_act", 32'(sif.act_addr), 0);
        chk("arst_wgt", 32'(sif.wgt_addr), 0);
        chk("arst_clr", 32'(sif.acc_clear), 0);
        chk("arst_lst", 32'(sif.acc_last), 0);
        chk("arst_we", 32'(sif.wr_en), 0);
        chk("arst_wad", 32'(sif.wr_addr), 0);
        chk("arst_cs", 32'(sif.change_state), 0);
        chk("arst_busy", 32'(sif.busy), 0);
        sif.state = 3'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        set_cfg(3'd1, 8'd2, 8'd2, 8'd3, 16'h100, 16'h200, 16'h300);
        run_rec(20, 0, 0, 0, 0);
        check_layer("post_rst", 0, 20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
